// File: rtl/regfile_rename_pkg.sv
// Shared constants for the architectural register file and rename table.
// Optional commit bypass is enabled by REGFILE_COMMIT_BYPASS_EN.
package regfile_rename_pkg;

  localparam int REG_NUM    = 32;
  localparam int REG_WIDTH  = 5;
  localparam int DATA_WIDTH = 32;
  localparam int TAG_WIDTH  = 5;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [TAG_WIDTH-1:0]  EMPTY_TAG  = '0;
  localparam logic [DATA_WIDTH-1:0] EMPTY_DATA = '0;

  function automatic logic is_x0(
    input logic [REG_WIDTH-1:0] idx
  );
    return idx == '0;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational source-operand read port: x0 forcing and,
// with REGFILE_COMMIT_BYPASS_EN, same-cycle forwarding of the commit.
module regfile_read_port
  import regfile_rename_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int TAG_W  = TAG_WIDTH,
  parameter int ADDR_W = REG_WIDTH
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic [TAG_W-1:0]  reg_tag,
  input  logic              commit_vld,
  input  logic [ADDR_W-1:0] commit_rd,
  input  logic [DATA_W-1:0] commit_data,
  input  logic [TAG_W-1:0]  commit_tag,
  output logic [DATA_W-1:0] data,
  output logic [TAG_W-1:0]  tag
);

`ifndef REGFILE_COMMIT_BYPASS_EN
  logic unused_bp;
  assign unused_bp = ^{commit_vld, commit_rd,
                       commit_data, commit_tag};
`endif

  // Select stored value, optionally forward commit, force x0.
  always_comb begin
    data = reg_data;
    tag  = reg_tag;
`ifdef REGFILE_COMMIT_BYPASS_EN
    if (commit_vld &&
        commit_rd == addr &&
        reg_tag == commit_tag) begin
      data = commit_data;
      tag  = '0;
    end
`endif
    if (addr == '0) begin
      data = '0;
      tag  = '0;
    end
  end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags.
// Build option: REGFILE_COMMIT_BYPASS_EN forwards commits to reads.
module regfile_rename
  import regfile_rename_pkg::*;
#(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 5,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic [ADDR_W-1:0] rs1_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [TAG_W-1:0]  rs1_tag,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs2_data,
  output logic [TAG_W-1:0]  rs2_tag,
  input  logic              rename_en,
  input  logic [ADDR_W-1:0] rename_rd,
  input  logic [TAG_W-1:0]  rename_tag,
  input  logic              commit_en,
  input  logic [ADDR_W-1:0] commit_rd,
  input  logic [DATA_W-1:0] commit_data,
  input  logic [TAG_W-1:0]  commit_tag
);

  logic [DATA_W-1:0] data_q [REG_NUM];
  logic [TAG_W-1:0]  tag_q  [REG_NUM];

  logic [REG_NUM-1:0] cm_hit;
  logic [REG_NUM-1:0] rn_hit;
  logic               commit_vld;

  assign commit_vld = commit_en && rdy;

  // Decode which register each write port targets.
  always_comb begin
    cm_hit = '0;
    rn_hit = '0;
    for (int i = 1; i < REG_NUM; i++) begin
      cm_hit[i] = commit_en &&
                  commit_rd == ADDR_W'(i);
      rn_hit[i] = rename_en &&
                  rename_rd == ADDR_W'(i);
    end
  end

  // Commit writes data; tags follow clear > rename > retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else if (rdy) begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (cm_hit[i])
          data_q[i] <= commit_data;
        if (clear)
          tag_q[i] <= '0;
        else if (rn_hit[i])
          tag_q[i] <= rename_tag;
        else if (cm_hit[i] &&
                 tag_q[i] == commit_tag)
          tag_q[i] <= '0;
      end
    end
  end

  regfile_read_port #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .ADDR_W (ADDR_W)
  ) u_rd1 (
    .addr        (rs1_addr),
    .reg_data    (data_q[rs1_addr]),
    .reg_tag     (tag_q[rs1_addr]),
    .commit_vld  (commit_vld),
    .commit_rd   (commit_rd),
    .commit_data (commit_data),
    .commit_tag  (commit_tag),
    .data        (rs1_data),
    .tag         (rs1_tag)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .ADDR_W (ADDR_W)
  ) u_rd2 (
    .addr        (rs2_addr),
    .reg_data    (data_q[rs2_addr]),
    .reg_tag     (tag_q[rs2_addr]),
    .commit_vld  (commit_vld),
    .commit_rd   (commit_rd),
    .commit_data (commit_data),
    .commit_tag  (commit_tag),
    .data        (rs2_data),
    .tag         (rs2_tag)
  );

  // A rename must always carry a real ROB tag.
  a_rename_tag : assert property (
    @(posedge clk) disable iff (rst)
    rename_en |-> rename_tag != EMPTY_TAG
  );

endmodule

// File: tb/tb_regfile_rename.sv
// Randomized + directed bench for regfile_rename
// against a behavioural register/tag array model.
module tb_regfile_rename;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rs1_tag, rs2_tag;
  logic        rename_en, commit_en;
  logic [4:0]  rename_rd, rename_tag;
  logic [4:0]  commit_rd, commit_tag;
  logic [31:0] commit_data;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_data [32];
  logic [4:0]  m_tag  [32];

  always #5 clk = ~clk;

  regfile_rename dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .clear       (clear),
    .rs1_addr    (rs1_addr),
    .rs1_data    (rs1_data),
    .rs1_tag     (rs1_tag),
    .rs2_addr    (rs2_addr),
    .rs2_data    (rs2_data),
    .rs2_tag     (rs2_tag),
    .rename_en   (rename_en),
    .rename_rd   (rename_rd),
    .rename_tag  (rename_tag),
    .commit_en   (commit_en),
    .commit_rd   (commit_rd),
    .commit_data (commit_data),
    .commit_tag  (commit_tag)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic model_read(input  logic [4:0]  a,
                            output logic [31:0] d,
                            output logic [4:0]  t);
    d = m_data[a];
    t = m_tag[a];
`ifdef REGFILE_COMMIT_BYPASS_EN
    if (!rst && rdy && commit_en &&
        commit_rd == a && m_tag[a] == commit_tag) begin
      d = commit_data;
      t = 0;
    end
`endif
    if (a == 0) begin
      d = 0;
      t = 0;
    end
  endtask

  task automatic idle();
    rst = 0; rdy = 1; clear = 0;
    rename_en = 0; rename_rd = 0; rename_tag = 1;
    commit_en = 0; commit_rd = 0;
    commit_data = 0; commit_tag = 1;
  endtask

  // compare both ports, clock once, advance the model
  task automatic cyc();
    logic [31:0] d;
    logic [4:0]  t;
    #1;
    model_read(rs1_addr, d, t);
    chk("rs1_data", rs1_data, d);
    chk("rs1_tag", 32'(rs1_tag), 32'(t));
    model_read(rs2_addr, d, t);
    chk("rs2_data", rs2_data, d);
    chk("rs2_tag", 32'(rs2_tag), 32'(t));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_data[i] = 0;
        m_tag[i]  = 0;
      end
    end else if (rdy) begin
      if (commit_en && commit_rd != 0) begin
        m_data[commit_rd] = commit_data;
        if (m_tag[commit_rd] == commit_tag)
          m_tag[commit_rd] = 0;
      end
      if (rename_en && rename_rd != 0)
        m_tag[rename_rd] = rename_tag;
      if (clear)
        for (int i = 0; i < 32; i++) m_tag[i] = 0;
    end
    #1;
  endtask

  task automatic rd_chk(input string nm,
                        input logic [4:0] a,
                        input logic [31:0] ed,
                        input logic [4:0]  et);
    rs1_addr = a;
    #1;
    chk({nm, "_data"}, rs1_data, ed);
    chk({nm, "_tag"}, 32'(rs1_tag), 32'(et));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_data[i] = 'x;
      m_tag[i]  = 'x;
    end
    idle();
    rs1_addr = 5; rs2_addr = 0;
    rst = 1;
    @(posedge clk); #1;
    cyc();
    idle();
    rd_chk("rst_x5", 5, 32'h0, 5'd0);
    #1 chk("rst_rs2", rs2_data, 32'h0);

    rename_en = 1; rename_rd = 5; rename_tag = 3;
    cyc(); idle();
    rd_chk("ren_x5", 5, 32'h0, 5'd3);

    commit_en = 1; commit_rd = 5;
    commit_data = 32'hDEAD; commit_tag = 3;
    rs1_addr = 5;
    cyc(); idle();
    rd_chk("cm_x5", 5, 32'hDEAD, 5'd0);

    rename_en = 1; rename_rd = 7; rename_tag = 2;
    cyc();
    rename_tag = 4;
    cyc(); idle();
    commit_en = 1; commit_rd = 7;
    commit_data = 32'h11; commit_tag = 2;
    cyc(); idle();
    rd_chk("young_x7", 7, 32'h11, 5'd4);

    commit_en = 1; commit_rd = 9;
    commit_data = 32'h55; commit_tag = 6;
    rename_en = 1; rename_rd = 9; rename_tag = 8;
    cyc(); idle();
    rd_chk("same_x9", 9, 32'h55, 5'd8);

    rename_en = 1; rename_rd = 1; rename_tag = 1;
    cyc();
    rename_rd = 2; rename_tag = 2;
    cyc(); idle();
    clear = 1;
    commit_en = 1; commit_rd = 1;
    commit_data = 32'h77; commit_tag = 1;
    rename_en = 1; rename_rd = 3; rename_tag = 5;
    cyc(); idle();
    rd_chk("clr_x1", 1, 32'h77, 5'd0);
    rd_chk("clr_x2", 2, 32'h0, 5'd0);
    rd_chk("clr_x3", 3, 32'h0, 5'd0);
    rd_chk("clr_x7", 7, 32'h11, 5'd0);

    rename_en = 1; rename_rd = 0; rename_tag = 1;
    commit_en = 1; commit_rd = 0;
    commit_data = 32'hFF; commit_tag = 1;
    cyc(); idle();
    rd_chk("x0", 0, 32'h0, 5'd0);

    rdy = 0;
    commit_en = 1; commit_rd = 5;
    commit_data = 32'hBEEF; commit_tag = 0;
    rename_en = 1; rename_rd = 6; rename_tag = 9;
    cyc(); idle();
    rd_chk("hold_x5", 5, 32'hDEAD, 5'd0);
    rd_chk("hold_x6", 6, 32'h0, 5'd0);

    for (int n = 0; n < 600; n++) begin
      idle();
      rdy   = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      rs1_addr = 5'($urandom_range(0, 31));
      rs2_addr = 5'($urandom_range(0, 31));
      rename_en  = ($urandom_range(0, 1) == 1);
      rename_rd  = 5'($urandom_range(0, 31));
      rename_tag = 5'($urandom_range(1, 15));
      commit_en  = ($urandom_range(0, 1) == 1);
      commit_rd  = 5'($urandom_range(0, 31));
      commit_data = $urandom;
      if ($urandom_range(0, 9) < 6 &&
          m_tag[commit_rd] != 0)
        commit_tag = m_tag[commit_rd];
      else
        commit_tag = 5'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0)
        rs1_addr = commit_rd;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
